// File: rtl/ad5791_init_sequencer.sv
// Power-on configuration sequencer for the four-channel AD5791 PMOD SPI DAC serializer.
// Define AD5791_SEQ_CLEARCODE_EN to add a clearcode-register phase after the control-register phase.
module ad5791_init_sequencer #(
    parameter int NUM_DAC           = 4,
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int LOAD_HOLD         = 8,
    parameter int FRAME_WAIT        = 160,
    parameter int RELEASE_HOLD      = 8
) (
    input  logic                         a_clk,
    input  logic                         a_rst,
    input  logic                         start,
    input  logic                         abort,
    input  logic [19:0]                  ctrl_payload,
    input  logic [19:0]                  clr_payload,
    output logic [SAXIS_TDATA_WIDTH-1:0] cfg_tdata,
    output logic                         cfg_tvalid,
    output logic                         configuration_mode,
    output logic [2:0]                   configuration_axis,
    output logic                         configuration_send,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [2:0] {
        S_IDLE, S_MODE_ENTER, S_LOAD, S_LOAD_GAP, S_SEND, S_RELEASE, S_EXIT
    } state_t;

    typedef enum logic {PH_CTRL, PH_CLR} phase_t;

    localparam int         TW        = 16;
    localparam logic [2:0] ADDR_CTRL = 3'b010;
    localparam logic [2:0] ADDR_CLR  = 3'b011;

`ifdef AD5791_SEQ_CLEARCODE_EN
    localparam bit HAS_CLR = 1'b1;
    logic [19:0] clr_sel;
    assign clr_sel = clr_payload;
`else
    localparam bit HAS_CLR = 1'b0;
    logic [19:0] clr_sel;
    logic        unused_clr;
    assign clr_sel    = '0;
    assign unused_clr = ^clr_payload;
`endif

    state_t         state_q, state_d;
    phase_t         phase_q, phase_d;
    logic [2:0]     axis_q, axis_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [23:0]    word;

    // Payloads are used live; software keeps them stable while busy is high.
    assign word = (phase_q == PH_CLR) ? {1'b0, ADDR_CLR, clr_sel}
                                      : {1'b0, ADDR_CTRL, ctrl_payload};

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_q <= S_IDLE;
            phase_q <= PH_CTRL;
            axis_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            axis_q  <= axis_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d            = state_q;
        phase_d            = phase_q;
        axis_d             = axis_q;
        timer_d            = timer_q;
        cfg_tdata          = '0;
        cfg_tvalid         = 1'b0;
        configuration_mode = 1'b0;
        configuration_axis = '0;
        configuration_send = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) state_d = S_MODE_ENTER;
            end
            S_MODE_ENTER: begin
                configuration_mode = 1'b1;
                busy               = 1'b1;
                axis_d             = '0;
                phase_d            = PH_CTRL;
                timer_d            = '0;
                state_d            = S_LOAD;
            end
            S_LOAD: begin
                configuration_mode = 1'b1;
                busy               = 1'b1;
                cfg_tvalid         = 1'b1;
                configuration_axis = axis_q;
                cfg_tdata          = SAXIS_TDATA_WIDTH'(word);
                if (timer_q == TW'(LOAD_HOLD - 1)) begin
                    timer_d = '0;
                    state_d = S_LOAD_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_LOAD_GAP: begin
                configuration_mode = 1'b1;
                busy               = 1'b1;
                if (axis_q < 3'(NUM_DAC - 1)) begin
                    axis_d  = axis_q + 3'd1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                configuration_mode = 1'b1;
                busy               = 1'b1;
                configuration_send = 1'b1;
                if (timer_q == TW'(FRAME_WAIT - 1)) begin
                    timer_d = '0;
                    state_d = S_RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RELEASE: begin
                configuration_mode = 1'b1;
                busy               = 1'b1;
                // The next-phase decision is folded into the last release cycle.
                if (timer_q == TW'(RELEASE_HOLD - 1)) begin
                    timer_d = '0;
                    if (HAS_CLR && phase_q == PH_CTRL) begin
                        phase_d = PH_CLR;
                        axis_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_EXIT;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_EXIT: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            phase_d = PH_CTRL;
            axis_d  = '0;
            timer_d = '0;
        end
    end

endmodule

// File: tb/tb_ad5791_init_sequencer.sv
// Scoreboard bench for ad5791_init_sequencer: stimulus queues expected load/send/done events,
// a negedge monitor reconstructs them from the DUT outputs and compares.
module tb_ad5791_init_sequencer;

    localparam int LOAD_LEN = 8;
    localparam int SEND_LEN = 160;
`ifdef AD5791_SEQ_CLEARCODE_EN
    localparam int EXP_LAT  = 411;
    localparam int EXP_MODE = 409;
`else
    localparam int EXP_LAT  = 207;
    localparam int EXP_MODE = 205;
`endif

    logic        a_clk = 1'b0;
    logic        a_rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] ctrl_payload = '0;
    logic [19:0] clr_payload  = 20'h80000;
    logic [31:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        configuration_mode;
    logic [2:0]  configuration_axis;
    logic        configuration_send;
    logic        busy;
    logic        done;

    ad5791_init_sequencer dut (
        .a_clk              (a_clk),
        .a_rst              (a_rst),
        .start              (start),
        .abort              (abort),
        .ctrl_payload       (ctrl_payload),
        .clr_payload        (clr_payload),
        .cfg_tdata          (cfg_tdata),
        .cfg_tvalid         (cfg_tvalid),
        .configuration_mode (configuration_mode),
        .configuration_axis (configuration_axis),
        .configuration_send (configuration_send),
        .busy               (busy),
        .done               (done)
    );

    always #5 a_clk = ~a_clk;

    typedef enum int {EV_LOAD, EV_SEND, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          axis;
        logic [31:0] data;
        int          len;
        int          len2;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic void push_ev(ev_kind_t k, int ax, logic [31:0] d, int l, int l2);
        exp_t e;
        e.kind = k;
        e.axis = ax;
        e.data = d;
        e.len  = l;
        e.len2 = l2;
        exp_q.push_back(e);
    endfunction

    task automatic push_run(input logic [31:0] ctrl_word);
        for (int i = 0; i < 4; i++) push_ev(EV_LOAD, i, ctrl_word, LOAD_LEN, 0);
        push_ev(EV_SEND, 0, 32'h0, SEND_LEN, 0);
`ifdef AD5791_SEQ_CLEARCODE_EN
        for (int i = 0; i < 4; i++) push_ev(EV_LOAD, i, 32'h00380000, LOAD_LEN, 0);
        push_ev(EV_SEND, 0, 32'h0, SEND_LEN, 0);
`endif
        push_ev(EV_DONE, 0, 32'h0, EXP_LAT, EXP_MODE);
    endtask

    task automatic pop_ev(input ev_kind_t k, input string name, output exp_t e, output bit ok);
        n_tests++;
        ok = 1'b0;
        e  = '{EV_LOAD, 0, 32'h0, 0, 0};
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected event kind %0d, expected no event", name, k);
        end else if (exp_q[0].kind != k) begin
            n_fail++;
            $display("FAIL %s: got event kind %0d, expected kind %0d", name, k, exp_q[0].kind);
            void'(exp_q.pop_front());
        end else begin
            e  = exp_q.pop_front();
            ok = 1'b1;
        end
    endtask

    // Monitor state: runs of tvalid/send, and per-sequence timing.
    logic        tv_prev = 1'b0, sd_prev = 1'b0, busy_prev = 1'b0;
    logic [2:0]  run_axis;
    logic [31:0] run_data;
    int          run_len = 0, send_len = 0;
    logic        run_bad = 1'b0, overlap = 1'b0, mode_err = 1'b0;
    int          cyc = 0, busy_cyc = 0, mode_cnt = 0;

    always @(negedge a_clk) begin
        exp_t e;
        bit   ok;
        cyc++;
        if (busy && !busy_prev) begin
            busy_cyc = cyc;
            mode_cnt = 0;
            overlap  = 1'b0;
        end
        if (configuration_mode) mode_cnt++;
        if (configuration_mode !== busy) mode_err = 1'b1;
        if (cfg_tvalid && configuration_send) overlap = 1'b1;

        if (cfg_tvalid) begin
            if (!tv_prev) begin
                run_axis = configuration_axis;
                run_data = cfg_tdata;
                run_len  = 1;
                run_bad  = 1'b0;
            end else begin
                run_len++;
                if (configuration_axis !== run_axis || cfg_tdata !== run_data) run_bad = 1'b1;
            end
        end else if (tv_prev) begin
            pop_ev(EV_LOAD, "load_event", e, ok);
            if (ok) begin
                check("load_axis", 32'(run_axis), e.axis);
                check("load_tdata", run_data, e.data);
                check("load_hold", run_len, e.len);
                check("load_stable", 32'(run_bad), 32'h0);
            end
        end

        if (configuration_send) begin
            send_len = sd_prev ? send_len + 1 : 1;
        end else if (sd_prev) begin
            pop_ev(EV_SEND, "send_event", e, ok);
            if (ok) check("send_len", send_len, e.len);
        end

        if (done) begin
            pop_ev(EV_DONE, "done_event", e, ok);
            // Latency counts the start-sampling cycle, busy cycles, and the done cycle inclusive.
            if (ok) begin
                check("done_latency", cyc - busy_cyc + 2, e.len);
                check("mode_cycles", mode_cnt, e.len2);
                check("send_tvalid_overlap", 32'(overlap), 32'h0);
            end
        end

        tv_prev   = cfg_tvalid;
        sd_prev   = configuration_send;
        busy_prev = busy;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge a_clk);
            n++;
        end
        check(name, 32'(done), 32'h1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_tdata"}, cfg_tdata, 32'h0);
        check({name, "_ctrl"}, {24'h0, cfg_tvalid, configuration_mode, configuration_axis,
                                configuration_send, busy, done}, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge a_clk);
        a_rst = 1'b0;
        check_all_zero("reset");

        // abort beats start in IDLE; abort alone in IDLE is a no-op
        start = 1'b1;
        abort = 1'b1;
        @(negedge a_clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_priority_busy", 32'(busy), 32'h0);
        abort = 1'b1;
        @(negedge a_clk);
        abort = 1'b0;
        check_all_zero("abort_idle");

        // Full sequence, with a stray start mid-run that must be ignored
        ctrl_payload = 20'h00012;
        push_run(32'h00200012);
        pulse_start();
        repeat (50) @(negedge a_clk);
        pulse_start();
        wait_done("run1_done");
        repeat (5) @(negedge a_clk);
        check("run1_no_requeue_busy", 32'(busy), 32'h0);

        // abort during SEND, sampled 100 edges after the start-sample edge
        ctrl_payload = 20'hABCDE;
        for (int i = 0; i < 4; i++) push_ev(EV_LOAD, i, 32'h002ABCDE, LOAD_LEN, 0);
        push_ev(EV_SEND, 0, 32'h0, 63, 0);
        pulse_start();
        repeat (99) @(negedge a_clk);
        abort = 1'b1;
        @(negedge a_clk);
        abort = 1'b0;
        check_all_zero("after_abort");
        repeat (300) @(negedge a_clk);
        check("abort_stays_idle", 32'(busy), 32'h0);

        // start held high: exactly one re-run after returning to IDLE
        ctrl_payload = 20'hFFFFF;
        push_run(32'h002FFFFF);
        push_run(32'h002FFFFF);
        start = 1'b1;
        wait_done("held_run1_done");
        begin
            int n = 0;
            @(negedge a_clk);
            while (!busy && n < 10) begin
                @(negedge a_clk);
                n++;
            end
        end
        check("held_restart_busy", 32'(busy), 32'h1);
        start = 1'b0;
        wait_done("held_run2_done");
        repeat (20) @(negedge a_clk);
        check("held_single_rerun", 32'(busy), 32'h0);

        // a_rst in LOAD of axis 2, then a fresh full run
        ctrl_payload = 20'h00012;
        push_ev(EV_LOAD, 0, 32'h00200012, LOAD_LEN, 0);
        push_ev(EV_LOAD, 1, 32'h00200012, LOAD_LEN, 0);
        push_ev(EV_LOAD, 2, 32'h00200012, 3, 0);
        pulse_start();
        repeat (21) @(negedge a_clk);
        a_rst = 1'b1;
        @(negedge a_clk);
        a_rst = 1'b0;
        check_all_zero("after_reset");
        repeat (3) @(negedge a_clk);
        push_run(32'h00200012);
        pulse_start();
        wait_done("post_reset_done");

        repeat (5) @(negedge a_clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check("mode_equals_busy", 32'(mode_err), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ad5791_init_sequencer.md
Name: ad5791_init_sequencer

Overview:
- Single-clock controller that brings the four-channel AD5791 PMOD SPI DAC serializer out of power-on state.
- Drives the serializer's configuration-mode side port in order: configuration_mode, configuration_axis, configuration_send, and the S_AXISCFG tdata/tvalid stream.
- Programs the control register of every channel, optionally the clearcode register, then releases the serializer to normal streaming mode.
- Sits between the PS-side config registers and the serializer.

Parameters:
NUM_DAC, 4, number of DAC channels/axes to program (1..4)
SAXIS_TDATA_WIDTH, 32, width of cfg_tdata
LOAD_HOLD, 8, a_clk cycles cfg_tvalid is held per axis; must be >= 4 (one serializer clock = 4 a_clk)
FRAME_WAIT, 160, a_clk cycles configuration_send is held high; must exceed one 24-bit SPI frame plus sync overhead (>= 120)
RELEASE_HOLD, 8, a_clk cycles configuration_send is held low after each frame

Ports:
a_clk  input  1  system clock, 120 MHz
a_rst  input  1  synchronous reset, active-high
start  input  1  begin the init sequence; sampled only in IDLE
abort  input  1  abandon the sequence; takes priority over start
ctrl_payload  input  20  AD5791 control-register payload, common to all axes
clr_payload  input  20  clearcode-register payload, used only with the optional feature
cfg_tdata  output  SAXIS_TDATA_WIDTH  word to serializer: {zeros, R/W=0, addr[2:0], payload[19:0]}
cfg_tvalid  output  1  cfg_tdata valid
configuration_mode  output  1  puts the serializer in config mode
configuration_axis  output  3  target axis index for cfg_tdata
configuration_send  output  1  frame-send request to the serializer
busy  output  1  sequence in progress
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: all outputs 0. State is IDLE, axis counter 0, timer 0, phase CTRL.
- Word format: bits[23] = 0; bits[22:20] = 3'b010 for CTRL or 3'b011 for CLR; bits[19:0] = payload; bits above 23 = 0.
- IDLE:
  - Outputs are 0.
  - start=1 and abort=0 -> MODE_ENTER. busy=1 and configuration_mode=1 from the next cycle.
- MODE_ENTER: one cycle. Axis counter = 0, phase = CTRL.
- LOAD:
  - cfg_tvalid=1, configuration_axis = axis counter, cfg_tdata = word for the current phase, held for LOAD_HOLD cycles.
  - Then go to LOAD_GAP.
- LOAD_GAP: one cycle with cfg_tvalid=0.
  - If axis counter < NUM_DAC-1: increment it and return to LOAD.
  - Otherwise go to SEND.
- configuration_send stays 0 throughout LOAD and LOAD_GAP. This lets the serializer re-arm its one-shot send latch.
- SEND: configuration_send=1 for FRAME_WAIT cycles, cfg_tvalid=0, then go to RELEASE.
- RELEASE: configuration_send=0 for RELEASE_HOLD cycles, then go to NEXT_PHASE.
- NEXT_PHASE:
  - If another phase remains: axis counter = 0, advance phase, go to LOAD.
  - Otherwise go to EXIT.
- EXIT: configuration_mode=0, busy=0, done=1 for exactly one cycle, then go to IDLE.
- Configuration_mode is 1 in every state from MODE_ENTER through NEXT_PHASE.
- Per-phase duration: NUM_DAC*(LOAD_HOLD+1) + FRAME_WAIT + RELEASE_HOLD cycles. With defaults: 36 + 160 + 8 = 204 cycles.
- Start-to-done latency with defaults:
  - 1 (IDLE sample) + 1 (MODE_ENTER) + 204*phases + 1 (EXIT) = 207 cycles with one phase.
  - 411 cycles with two phases.
- abort:
  - In any non-IDLE state, the next cycle forces IDLE with all outputs 0.
  - done is not pulsed.
  - abort in IDLE has no effect.
- start while busy: ignored. No queuing.
- a_rst mid-sequence: same as abort. a_rst wins over abort and start.
- Payload inputs are sampled live, not latched. Software must hold them stable while busy=1.
- Identical words: if a phase loads words equal to what the serializer already holds, no SPI frame occurs. The sequencer still runs SEND/RELEASE on its timer; this is not an error.

Optional Feature:
- Macro: AD5791_SEQ_CLEARCODE_EN.
- Defined: two phases, CTRL then CLR. The CLR phase writes clr_payload with address 3'b011 to every axis. Latency is 411 cycles with defaults.
- Undefined: CTRL phase only. clr_payload is unused. Latency is 207 cycles with defaults.

Test Plan:
1. Reset, then start pulse, ctrl_payload=20'h00012 (feature off) -> done exactly 207 cycles after the start sample edge.
   - Axes 0..3 each see cfg_tvalid high for 8 cycles with cfg_tdata=32'h00200012.
   - configuration_send is high for 160 cycles, and configuration_mode is high for the whole sequence.
2. With AD5791_SEQ_CLEARCODE_EN defined, clr_payload=20'h80000 -> the second phase sends 32'h00380000 on axes 0..3; done arrives at cycle 411.
3. Assert abort during SEND (cycle 100) -> the next cycle has configuration_send=0, configuration_mode=0, busy=0, and done never pulses.
4. start held high through a full run -> exactly one sequence runs. After done, start (still high) is sampled in IDLE and a second sequence starts; no start edges are lost or duplicated.
5. Assert a_rst in LOAD of axis 2 -> the next cycle has all outputs 0. A fresh start afterwards begins again at axis 0, phase CTRL.
6. Pair the block with the serializer model and check that a full 24-bit SPI frame (sync low for 24 bit clocks) occurs within each SEND window and that no frame occurs during LOAD.
